// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundle of the requester-side and broadcast-side signals of the common data
// bus arbiter.
//   req_valid / req_tag / req_data : per-requester results, packed by index
//   req_ready                      : one-hot-or-zero accept back to requesters
//   cdb_valid / cdb_tag / cdb_data : registered broadcast entry
//   cdb_src                        : index of the requester that produced it
//   cdb_ready                      : downstream can consume the entry
// Modports: master = functional units + downstream consumer, slave = arbiter.
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int TAG_W  = 7,
   parameter int DATA_W = 32
);
   localparam int SRC_W = $clog2(N_REQ);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*TAG_W-1:0]  req_tag;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    cdb_valid;
   logic                    cdb_ready;
   logic [TAG_W-1:0]        cdb_tag;
   logic [DATA_W-1:0]       cdb_data;
   logic [SRC_W-1:0]        cdb_src;

   modport master (
      output req_valid, req_tag, req_data, cdb_ready,
      input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );

   modport slave (
      input  req_valid, req_tag, req_data, cdb_ready,
      output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter that picks one functional-unit result per cycle and
// broadcasts it on the common data bus through a single output register.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset
//   flush  : pipeline flush, kills the broadcast entry and blocks accepts
//   bus    : cdb_arbiter_if slave modport (requests in, broadcast out)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int N_REQ  = 4,
   parameter int TAG_W  = 7,
   parameter int DATA_W = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   cdb_arbiter_if.slave   bus
);
   localparam int SRC_W = $clog2(N_REQ);

   logic [SRC_W-1:0]  ptr;
   logic              out_valid;
   logic [TAG_W-1:0]  out_tag;
   logic [DATA_W-1:0] out_data;
   logic [SRC_W-1:0]  out_src;

   logic              out_free;
   logic              win_found;
   logic [SRC_W-1:0]  win_idx;
   logic [SRC_W-1:0]  cand_idx;
   int                cand;
   logic              accept;
   logic [N_REQ-1:0]  ready_vec;
   logic [TAG_W-1:0]  win_tag;
   logic [DATA_W-1:0] win_data;

   // The output register can take a new entry when it is empty or when the
   // current entry is being consumed on this same edge.
   assign out_free = !out_valid || bus.cdb_ready;

   // Scan requesters starting at the round-robin pointer and wrapping at
   // N_REQ (not at a power of two), keeping the first valid one found.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         cand_idx = SRC_W'(cand);
         if (!win_found && bus.req_valid[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // A grant is only handed out when there is room downstream and no flush
   // or reset is in progress; since the grant goes to a valid requester the
   // grant itself is the accept.
   assign accept = win_found && out_free && !flush && !reset;

   // Decode the grant to one-hot and mux out the winner's payload using
   // constant slice positions.
   always_comb begin
      ready_vec = '0;
      win_tag   = '0;
      win_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_idx == SRC_W'(i)) begin
            ready_vec[i] = accept;
            win_tag      = bus.req_tag[i*TAG_W +: TAG_W];
            win_data     = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Output register and pointer. Reset beats everything; an accept loads a
   // fresh entry (possibly replacing one consumed this edge); otherwise a
   // flush or a downstream consume empties the register while the payload
   // keeps its last value. A stall simply holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= '0;
         out_valid <= 1'b0;
         out_tag   <= '0;
         out_data  <= '0;
         out_src   <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_tag   <= win_tag;
         out_data  <= win_data;
         out_src   <= win_idx;
         if (win_idx == SRC_W'(N_REQ-1)) begin
            ptr <= '0;
         end else begin
            ptr <= win_idx + SRC_W'(1);
         end
      end else if (flush || bus.cdb_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign bus.req_ready = ready_vec;
   assign bus.cdb_valid = out_valid;
   assign bus.cdb_tag   = out_tag;
   assign bus.cdb_data  = out_data;
   assign bus.cdb_src   = out_src;
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesting functional units; legal range 2..16.
REQ-002 Parameter TAG_W, default 7: physical-register tag width.
REQ-003 Parameter DATA_W, default 32: result data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  pipeline flush from commit logic.
REQ-007 req_valid  input  N_REQ  per-requester result-valid.
REQ-008 req_tag  input  N_REQ*TAG_W  per-requester tag; slice i = bits [i*TAG_W +: TAG_W].
REQ-009 req_data  input  N_REQ*DATA_W  per-requester data; slice i = bits [i*DATA_W +: DATA_W].
REQ-010 req_ready  output  N_REQ  one-hot-or-zero grant/accept, combinational.
REQ-011 cdb_valid  output  1  registered broadcast valid.
REQ-012 cdb_ready  input  1  downstream (ROB/RS wakeup) can consume this cycle.
REQ-013 cdb_tag  output  TAG_W  registered broadcast tag.
REQ-014 cdb_data  output  DATA_W  registered broadcast data.
REQ-015 cdb_src  output  clog2(N_REQ)  registered index of the winning requester.

Function
REQ-016 Internal state is a round-robin pointer ptr (clog2(N_REQ) bits) plus the output register (cdb_valid, cdb_tag, cdb_data, cdb_src).
REQ-017 out_free = !cdb_valid || cdb_ready.
REQ-018 Winner = first i with req_valid[i]=1, searching ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1 (wrap mod N_REQ, including non-power-of-two N_REQ).
REQ-019 req_ready[winner] = out_free && !flush && !reset; all other bits 0; all bits 0 when no req_valid is set.
REQ-020 Accept occurs when req_valid[i] && req_ready[i]; at most one accept per cycle.
REQ-021 On accept, the next edge loads cdb_valid=1 and copies the winner's tag and data, with cdb_src=winner; latency is exactly 1 cycle.
REQ-022 On accept, ptr <= (winner+1) mod N_REQ; without an accept, ptr holds.
REQ-023 With cdb_valid=1 and cdb_ready=0 (stall), cdb_valid, cdb_tag, cdb_data and cdb_src hold stable, and no accept occurs.
REQ-024 With cdb_ready=1 and no accept, cdb_valid <= 0 and the payload holds its last value.
REQ-025 Simultaneous cdb_ready=1 and accept: the old entry is consumed and the new one is loaded on the same edge; sustained throughput is 1 result per cycle.
REQ-026 flush=1: no accept, cdb_valid <= 0 next edge regardless of cdb_ready, and ptr holds.
REQ-027 Requester inputs are not sampled unless accepted; a requester dropping req_valid before acceptance is legal.
REQ-028 Fairness: a continuously valid requester is granted within N_REQ accepts.

Reset
REQ-029 reset=1 at an edge: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, ptr=0; req_ready=0 while reset is high.
REQ-030 Reset asserted mid-stall discards the pending output entry; reset has priority over flush and accept.
REQ-031 First cycle after reset release: arbitration starts from index 0.

Verification
REQ-032 After reset, req_valid=4'b1010 and cdb_ready=1 held -> grants 1, 3, 1, 3 on consecutive cycles; cdb_src 1 appears one cycle after the first grant.
REQ-033 All four requesters valid with cdb_ready=1 -> grant order 0,1,2,3,0 and cdb_valid continuously 1 from cycle 2.
REQ-034 Requester 2 accepted (tag=7'h15, data=32'hDEADBEEF), then cdb_ready=0 for 3 cycles -> outputs stable and req_ready=0 throughout; cdb_ready=1 -> the next pending requester is accepted on that cycle.
REQ-035 cdb_valid=1 while stalled, then flush=1 for one cycle -> cdb_valid=0 next cycle, no accept during flush, ptr unchanged.
REQ-036 Reset asserted during a stall with req_valid=4'b1111 -> outputs zeroed, req_ready=0; after release, requester 0 is granted first.
REQ-037 N_REQ=3, all valid -> grant order 0,1,2,0 (non-power-of-two wrap is correct).
